// File: rtl/multiplier_seq.sv
// Iterative signed shift-and-add multiplier. Works on operand magnitudes and
// retires one multiplier bit per cycle, stopping early once the multiplier is empty.
module multiplier_seq #(
   parameter int A_WIDTH = 32,
   parameter int B_WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [A_WIDTH-1:0]         multiplicand,
   input  logic [B_WIDTH-1:0]         multiplier,
   output logic [A_WIDTH+B_WIDTH-1:0] product,
   output logic                       busy,
   output logic                       done
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t               state;
   logic [P_WIDTH-1:0]   mcand_r;
   logic [B_WIDTH-1:0]   mplier_r;
   logic [P_WIDTH-1:0]   acc;
   logic                 sign_r;

   logic [A_WIDTH-1:0]   abs_a;
   logic [B_WIDTH-1:0]   abs_b;

   // The most negative operand negates to itself, which read unsigned is 2^(W-1).
   always_comb begin
      abs_a = multiplicand[A_WIDTH-1] ? (~multiplicand + A_WIDTH'(1)) : multiplicand;
      abs_b = multiplier[B_WIDTH-1]   ? (~multiplier   + B_WIDTH'(1)) : multiplier;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc      <= '0;
         sign_r   <= 1'b0;
         product  <= '0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand_r  <= {{B_WIDTH{1'b0}}, abs_a};
                  mplier_r <= abs_b;
                  acc      <= '0;
                  sign_r   <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
                  state    <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (mplier_r == '0) begin
                  state <= DONE;
               end else begin
                  if (mplier_r[0])
                     acc <= acc + mcand_r;
                  mcand_r  <= mcand_r << 1;
                  mplier_r <= mplier_r >> 1;
               end
            end
            DONE: begin
               // A zero magnitude with sign_r set negates back to zero.
               product <= sign_r ? (~acc + P_WIDTH'(1)) : acc;
               done    <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: vector table for product/latency plus
// hand sequences for held start, back-to-back, and reset interactions.
module tb_multiplier_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [63:0] product;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   multiplier_seq #(.A_WIDTH(32), .B_WIDTH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called one step after the accepting edge; counts edges until done is seen.
   task automatic wait_done(input bit scramble, output int lat, output bit busy_ok);
      lat = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         if (scramble) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
         end
         @(posedge clock); #1;
         if (done) begin
            lat = i;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat, output bit busy_ok);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(1'b0, lat, busy_ok);
   endtask

   int lat;
   bit bok;
   bit saw_done;

   initial begin
      vecs[0]  = '{32'd7,          32'd6,          64'd42,                   5};
      vecs[1]  = '{-32'sd3,        32'd5,          64'hFFFF_FFFF_FFFF_FFF1,  5};
      vecs[2]  = '{32'd3,          -32'sd5,        64'hFFFF_FFFF_FFFF_FFF1,  5};
      vecs[3]  = '{32'd12345,      32'd0,          64'd0,                    2};
      vecs[4]  = '{-32'sd9,        32'd1,          64'hFFFF_FFFF_FFFF_FFF7,  3};
      vecs[5]  = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 34};
      vecs[6]  = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000, 34};
      vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1,                    3};
      vecs[8]  = '{32'd0,          -32'sd7,        64'd0,                    5};
      vecs[9]  = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 19};
      vecs[10] = '{32'hFFFF_FFFF,  32'h4000_0000,  64'hFFFF_FFFF_C000_0000, 33};

      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_product", product, 64'd0);
      check("reset_done",    {63'd0, done}, 64'd0);
      check("reset_busy",    {63'd0, busy}, 64'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, lat, bok);
         check($sformatf("vec%0d_product", i), product, vecs[i].p);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("vec%0d_busy", i), {63'd0, bok}, 64'd1);
         @(posedge clock); #1;
         check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
      end

      // start held high with operands churning; next request taken right after done
      multiplicand = 32'd7;
      multiplier   = 32'd6;
      start        = 1'b1;
      @(posedge clock); #1;
      wait_done(1'b1, lat, bok);
      check("held_product", product, 64'd42);
      check("held_latency", 64'(lat), 64'd5);
      check("held_busy", {63'd0, bok}, 64'd1);
      multiplicand = 32'd2;
      multiplier   = 32'd2;
      @(posedge clock); #1;
      start = 1'b0;
      check("b2b_accept_busy", {63'd0, busy}, 64'd1);
      check("b2b_accept_done", {63'd0, done}, 64'd0);
      wait_done(1'b0, lat, bok);
      check("b2b_product", product, 64'd4);
      check("b2b_latency", 64'(lat), 64'd4);

      // reset in the third COMPUTE cycle of 7*6 discards the result
      @(posedge clock); #1;
      multiplicand = 32'd7;
      multiplier   = 32'd6;
      start        = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("mid_reset_busy",    {63'd0, busy}, 64'd0);
      check("mid_reset_done",    {63'd0, done}, 64'd0);
      check("mid_reset_product", product, 64'd0);
      saw_done = 1'b0;
      repeat (10) begin
         @(posedge clock); #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("mid_reset_no_done", {63'd0, saw_done}, 64'd0);
      run_op(32'd2, 32'd2, lat, bok);
      check("post_reset_product", product, 64'd4);
      check("post_reset_latency", 64'(lat), 64'd4);

      // reset and start on the same edge: request dropped
      @(posedge clock); #1;
      multiplicand = 32'd5;
      multiplier   = 32'd5;
      reset = 1'b1;
      start = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      start = 1'b0;
      check("reset_start_busy",    {63'd0, busy}, 64'd0);
      check("reset_start_product", product, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
